// File: rtl/pp_mult_pkg.sv
// Shared types and constants for the sequential partial-product multiplier.
package pp_mult_pkg;

  localparam int unsigned N_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Row-counter width: ceil(log2(n)), never below one bit.
  function automatic int unsigned clog2(input int unsigned n);
    for (int unsigned w = 1; w < 32; w++) begin
      if ((32'd1 << w) >= n) return w;
    end
    return 32;
  endfunction

endpackage

// File: rtl/pp_row_gen.sv
// One partial-product row: the multiplicand gated by a single multiplier bit.
module pp_row_gen
  import pp_mult_pkg::*;
#(
  parameter int unsigned N = N_DEFAULT
) (
  input  logic [N-1:0] a,
  input  logic         bsel,
  output logic [N-1:0] row
);

  assign row = a & {N{bsel}};

endmodule

// File: rtl/pp_seq_mult_ctrl.sv
// Sequential signed multiplier: one partial-product row accumulated per clock,
// with the multiplier MSB row subtracted for two's-complement weighting.
module pp_seq_mult_ctrl
  import pp_mult_pkg::*;
#(
  parameter int unsigned N = N_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N-1:0]    a,
  input  logic [N-1:0]    b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*N-1:0]  product,
  output logic            busy
);

  localparam int unsigned PW = 2 * N;
  localparam int unsigned CW = clog2(N);

  state_e          state_q;
  state_e          state_d;
  logic [N-1:0]    a_r;
  logic [N-1:0]    b_r;
  logic [PW-1:0]   acc;
  logic [CW-1:0]   cnt;

  logic [N-1:0]    row_c;
  logic [PW-1:0]   shifted_c;
  logic            last_c;
  logic            accept_c;

  pp_row_gen #(.N(N)) u_row_gen (
    .a    (a_r),
    .bsel (b_r[cnt]),
    .row  (row_c)
  );

  // Sign-extend the row (multiplicand is signed) and align it to its bit weight.
  assign shifted_c = {{N{row_c[N-1]}}, row_c} << cnt;
  assign last_c    = (cnt == CW'(N - 1));
  assign accept_c  = (state_q == IDLE) && in_valid;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)  state_d = BUSY;
      BUSY:    if (last_c)    state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Operand capture and row accumulation; the MSB row carries negative weight.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r <= '0;
      b_r <= '0;
      acc <= '0;
      cnt <= '0;
    end else if (accept_c) begin
      a_r <= a;
      b_r <= b;
      acc <= '0;
      cnt <= '0;
    end else if (state_q == BUSY) begin
      acc <= last_c ? (acc - shifted_c) : (acc + shifted_c);
      cnt <= cnt + CW'(1);
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == BUSY);
  assign out_valid = (state_q == DONE);
  assign product   = acc;

endmodule

// File: tb/tb_pp_seq_mult_ctrl.sv
// Scoreboard bench for pp_seq_mult_ctrl: directed cases plus a shuffled sweep
// of every signed 4-bit operand pair with random output stalls.
module tb_pp_seq_mult_ctrl;

  localparam int unsigned N  = 4;
  localparam int unsigned PW = 2 * N;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  a;
  logic [N-1:0]  b;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] product;
  logic          busy;

  logic [PW-1:0] exp_q[$];
  int            n_vec = 0;
  int            n_err = 0;

  pp_seq_mult_ctrl #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain signed integer multiply, truncated to the product width.
  function automatic logic [PW-1:0] ref_prod(input logic [N-1:0] av, input logic [N-1:0] bv);
    int sa;
    int sb;
    sa = $signed(av);
    sb = $signed(bv);
    return PW'(sa * sb);
  endfunction

  // Monitor: every accepted result is popped and compared against the scoreboard.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_result: got product 0x%0h, required no result", product);
      end else begin
        check("product", 32'(product), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic run_op(input logic [N-1:0] av, input logic [N-1:0] bv, input int stall,
                        input bit hold_valid, output int lat, output int bcnt);
    int guard;
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    check("in_ready_before_accept", 32'(in_ready), 32'd1);
    a         = av;
    b         = bv;
    in_valid  = 1'b1;
    out_ready = (stall == 0);
    exp_q.push_back(ref_prod(av, bv));
    @(posedge clk); #1;
    if (!hold_valid) in_valid = 1'b0;
    a = N'($urandom);
    b = N'($urandom);
    lat  = 0;
    bcnt = 0;
    while (!out_valid && lat <= int'(N) + 4) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
    for (int s = 0; s < stall; s++) begin
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_product", 32'(product), 32'(ref_prod(av, bv)));
      check("hold_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("post_take_in_ready", 32'(in_ready), 32'd1);
    check("post_take_out_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    int lat;
    int bcnt;
    int idx[256];
    int tmp;
    int j;
    bit seen;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_product", 32'(product), 32'd0);

    // 3*5 with the consumer always ready: latency and busy length.
    run_op(4'd3, 4'd5, 0, 1'b0, lat, bcnt);
    check("latency_3x5", 32'(lat), 32'(N));
    check("busy_cycles_3x5", 32'(bcnt), 32'(N));

    // Corner operands.
    run_op(4'h8, 4'h8, 0, 1'b0, lat, bcnt);
    run_op(4'h8, 4'h7, 0, 1'b0, lat, bcnt);
    run_op(4'hF, 4'hF, 0, 1'b0, lat, bcnt);

    // Zero multiplicand still runs all rows; in_valid held through BUSY/DONE.
    run_op(4'h0, 4'hD, 0, 1'b1, lat, bcnt);
    check("latency_zero", 32'(lat), 32'(N));
    check("busy_cycles_zero", 32'(bcnt), 32'(N));
    repeat (3) @(posedge clk);
    #1;
    check("no_reaccept_in_ready", 32'(in_ready), 32'd1);
    check("no_reaccept_queue", 32'(exp_q.size()), 32'd0);

    // Backpressure: 7 * -2 held for 5 cycles.
    run_op(4'h7, 4'hE, 5, 1'b0, lat, bcnt);

    // Reset at cnt=2 of 5*6: result discarded, no out_valid pulse.
    a         = 4'd5;
    b         = 4'd6;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_product", 32'(product), 32'd0);
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (out_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    check("midrst_no_out_valid", 32'(seen), 32'd0);
    out_ready = 1'b0;
    run_op(4'd2, 4'hD, 0, 1'b0, lat, bcnt);

    // Shuffled sweep of all signed 4-bit pairs with random stalls and gaps.
    for (int k = 0; k < 256; k++) idx[k] = k;
    for (int k = 255; k > 0; k--) begin
      j      = int'($urandom_range(0, k));
      tmp    = idx[k];
      idx[k] = idx[j];
      idx[j] = tmp;
    end
    for (int k = 0; k < 256; k++) begin
      int stall;
      stall = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 4));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      run_op(N'(idx[k] >> 4), N'(idx[k]), stall, 1'($urandom_range(0, 1)), lat, bcnt);
      check("sweep_latency", 32'(lat), 32'(N));
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
